ramp_sequencer: RTL
===================

Name: ramp_sequencer

Overview:
- Controls the output-amplitude envelope of one DAC channel: ramp-up, hold, ramp-down.
- Each transition is aligned to a wrap of the channel's DDS phase.
- Ramp length is a power-of-two number of signal periods.
- Sits between the register block and the DAC multiplier. Takes the DDS phase AXIS stream plus start/stop commands and produces a 16-bit envelope, where 0 means muted and 8192 means unity gain.

Parameters:
PHASE_WIDTH, 48, width of s_axis_tdata_phase
PHASE_BITS, 13, top phase bits used as the intra-period ramp position (full scale 8192)
MAX_LOG2, 7, largest accepted cfg_ramp_log2; larger values are clamped

Ports:
clk  in  1  system clock
areset  in  1  asynchronous reset, active-high
s_axis_tdata_phase  in  PHASE_WIDTH  DDS phase; the top PHASE_BITS are used
s_axis_tvalid_phase  in  1  phase beat valid; no backpressure
cfg_enable_ramping  in  1  1 = phase-aligned ramps; 0 = hard switching
cfg_ramp_log2  in  4  ramp length = 2^cfg_ramp_log2 periods; sampled on accepted cmd_start
cmd_start  in  1  single-cycle start pulse
cmd_stop  in  1  single-cycle stop pulse
ramp  out  16  envelope, 0..8192
busy  out  1  high in ARMED, RAMP_UP, HOLD and RAMP_DOWN
state_o  out  3  current state encoding
ramp_up_done  out  1  single-cycle pulse on entry to HOLD
done  out  1  single-cycle pulse on entry to DONE

Behaviour:
- Reset (async): state=IDLE, ramp=0, busy=0, pulses=0, k=0, stop_pending=0, ph=0, ph_prev=0.
- Pipeline:
  - Stage 1: on tvalid, ph <= tdata[PW-1:PW-13] and ph_prev <= ph. Register wrap <= tvalid & (ph_new < ph).
  - Stage 2: state update and registered ramp.
  - ramp reflects a phase beat 2 clk after that beat's tvalid.
- Position: pos = ((k << 13) + ph) >> L, where L is the latched log2 and k counts 0..2^L-1. The sum fits in 21 bits; the result is always <= 8191.
- States, ramp value per state, and transitions:
  - IDLE (0), ramp 0: cmd_start goes to ARMED; L is latched; k=0.
  - ARMED (1), ramp 0: wrap goes to RAMP_UP. cmd_stop returns to IDLE.
  - RAMP_UP (2), ramp = pos: on wrap, if k == 2^L-1 go to HOLD (or RAMP_DOWN if stop_pending), k=0; else k++.
  - HOLD (3), ramp 8192: on wrap with stop_pending, go to RAMP_DOWN, k=0.
  - RAMP_DOWN (4), ramp = 8192 - pos: on wrap, if k == 2^L-1 go to DONE; else k++.
  - DONE (5), ramp 0: cmd_start goes to ARMED, same as from IDLE.
- stop_pending:
  - Set by cmd_stop in RAMP_UP or HOLD.
  - Cleared on entry to RAMP_DOWN or IDLE.
  - A cmd_stop in RAMP_DOWN or DONE is ignored.
- cmd_start is ignored outside IDLE/DONE.
- Simultaneous cmd_start and cmd_stop in IDLE/DONE: start wins; the stop is dropped.
- cfg_enable_ramping=0:
  - cmd_start goes directly to HOLD next cycle (ramp 8192, ramp_up_done pulses).
  - cmd_stop in HOLD goes directly to DONE next cycle.
  - The phase pipeline keeps running.
- Clearing cfg_enable_ramping mid-ramp does not abort the ramp. It only affects subsequent transitions.
- L=0 gives one-period ramps, where ramp equals ph (up) or 8192-ph (down).
- tvalid gaps: state and ramp hold their values; no wrap is generated.
- Reset asserted mid-ramp: immediate ramp=0 and IDLE.

Decomposition:
- Package ramp_seq_pkg holds:
  - state enum (IDLE..DONE, 3 bits)
  - RAMP_FULL=8192, PHASE_BITS=13, MAX_LOG2
- One sub-module, phase_wrap_detect: stage-1 phase capture and wrap pulse generation. It is reusable by other phase-aligned blocks.

Test Plan:
1. L=0, phase sawtooth with period 64 beats; start, then stop after 3 periods. ramp=0 until the first wrap, then rises with ph, holds 8192, falls as 8192-ph after the next wrap, then done pulses and ramp=0.
2. L=2: RAMP_UP lasts exactly 4 wraps. ramp at k=1, ph=0 is 2048; ramp_up_done is asserted on the 4th wrap.
3. cmd_stop during RAMP_UP at k=1, L=1: no HOLD state is visited, and RAMP_DOWN starts exactly at the ramp-up-complete wrap.
4. cfg_enable_ramping=0: start gives ramp=8192 one cycle later; stop gives DONE and ramp=0 one cycle later, independent of phase.
5. areset pulse during RAMP_DOWN with ramp≈4000: ramp=0 and state_o=0 asynchronously. A later start behaves as in scenario 1.
6. cfg_ramp_log2=12 is clamped to 7 (ramp lasts 128 wraps). Simultaneous start and stop in IDLE results in ARMED.

Source files
------------

// File: rtl/ramp_seq_pkg.sv
// rtl/ramp_seq_pkg.sv - shared state encoding and constants for the DAC envelope sequencer
package ramp_seq_pkg;

   localparam int          PHASE_BITS = 13;
   localparam int          MAX_LOG2   = 7;
   localparam logic [15:0] RAMP_FULL  = 16'd8192;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ARMED     = 3'd1,
      ST_RAMP_UP   = 3'd2,
      ST_HOLD      = 3'd3,
      ST_RAMP_DOWN = 3'd4,
      ST_DONE      = 3'd5
   } ramp_state_t;

endpackage

// File: rtl/phase_wrap_detect.sv
// rtl/phase_wrap_detect.sv - captures the top DDS phase bits and flags each period wrap
module phase_wrap_detect #(
   parameter int PHASE_WIDTH = 48,
   parameter int PHASE_BITS  = 13
) (
   input  logic                   clk,
   input  logic                   areset,
   input  logic [PHASE_WIDTH-1:0] s_axis_tdata_phase,
   input  logic                   s_axis_tvalid_phase,
   output logic [PHASE_BITS-1:0]  ph,
   output logic [PHASE_BITS-1:0]  ph_prev,
   output logic                   wrap
);

   logic [PHASE_BITS-1:0] ph_new;
   logic                  unused_low_bits;

   assign ph_new          = s_axis_tdata_phase[PHASE_WIDTH-1 -: PHASE_BITS];
   assign unused_low_bits = ^s_axis_tdata_phase[PHASE_WIDTH-PHASE_BITS-1:0];

   // A wrap is only recognised on a valid beat, so gaps never fake a period boundary.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         ph      <= '0;
         ph_prev <= '0;
         wrap    <= 1'b0;
      end else begin
         wrap <= s_axis_tvalid_phase && (ph_new < ph);
         if (s_axis_tvalid_phase) begin
            ph      <= ph_new;
            ph_prev <= ph;
         end
      end
   end

endmodule

// File: rtl/ramp_sequencer.sv
// rtl/ramp_sequencer.sv - phase-aligned ramp-up/hold/ramp-down envelope for one DAC channel
module ramp_sequencer #(
   parameter int PHASE_WIDTH = 48,
   parameter int PHASE_BITS  = ramp_seq_pkg::PHASE_BITS,
   parameter int MAX_LOG2    = ramp_seq_pkg::MAX_LOG2
) (
   input  logic                   clk,
   input  logic                   areset,
   input  logic [PHASE_WIDTH-1:0] s_axis_tdata_phase,
   input  logic                   s_axis_tvalid_phase,
   input  logic                   cfg_enable_ramping,
   input  logic [3:0]             cfg_ramp_log2,
   input  logic                   cmd_start,
   input  logic                   cmd_stop,
   output logic [15:0]            ramp,
   output logic                   busy,
   output logic [2:0]             state_o,
   output logic                   ramp_up_done,
   output logic                   done
);

   import ramp_seq_pkg::*;

   logic [PHASE_BITS-1:0]          ph;
   logic [PHASE_BITS-1:0]          ph_prev_unused;
   logic                           wrap;

   ramp_state_t                    state, state_n;
   logic [MAX_LOG2-1:0]            k, k_n, k_last;
   logic [3:0]                     l_q, l_n, l_clamped;
   logic                           stop_pending, stop_pending_n;
   logic [15:0]                    ramp_n;
   logic [MAX_LOG2+PHASE_BITS-1:0] acc;
   logic [PHASE_BITS-1:0]          pos;

   phase_wrap_detect #(
      .PHASE_WIDTH (PHASE_WIDTH),
      .PHASE_BITS  (PHASE_BITS)
   ) u_wrap (
      .clk                 (clk),
      .areset              (areset),
      .s_axis_tdata_phase  (s_axis_tdata_phase),
      .s_axis_tvalid_phase (s_axis_tvalid_phase),
      .ph                  (ph),
      .ph_prev             (ph_prev_unused),
      .wrap                (wrap)
   );

   assign l_clamped = (cfg_ramp_log2 > 4'(MAX_LOG2)) ? 4'(MAX_LOG2) : cfg_ramp_log2;
   assign k_last    = ~({MAX_LOG2{1'b1}} << l_q);

   always_comb begin
      state_n        = state;
      k_n            = k;
      l_n            = l_q;
      stop_pending_n = stop_pending;
      case (state)
         ST_IDLE, ST_DONE: begin
            // start wins over a simultaneous stop here
            if (cmd_start) begin
               l_n     = l_clamped;
               k_n     = '0;
               state_n = cfg_enable_ramping ? ST_ARMED : ST_HOLD;
            end
         end
         ST_ARMED: begin
            if (cmd_stop) begin
               state_n = ST_IDLE;
            end else if (wrap) begin
               state_n = ST_RAMP_UP;
               k_n     = '0;
            end
         end
         ST_RAMP_UP: begin
            if (cmd_stop) stop_pending_n = 1'b1;
            if (wrap) begin
               if (k == k_last) begin
                  k_n     = '0;
                  state_n = stop_pending ? ST_RAMP_DOWN : ST_HOLD;
               end else begin
                  k_n = k + 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (!cfg_enable_ramping && cmd_stop) begin
               state_n = ST_DONE;
            end else begin
               if (cmd_stop) stop_pending_n = 1'b1;
               if (wrap && stop_pending) begin
                  state_n = ST_RAMP_DOWN;
                  k_n     = '0;
               end
            end
         end
         ST_RAMP_DOWN: begin
            if (wrap) begin
               if (k == k_last) begin
                  k_n     = '0;
                  state_n = ST_DONE;
               end else begin
                  k_n = k + 1'b1;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase
      if (state_n != ST_RAMP_UP && state_n != ST_HOLD) stop_pending_n = 1'b0;
   end

   // Position within the whole ramp: k full periods plus the intra-period phase, scaled by 2^-L.
   assign acc = {k_n, ph};
   assign pos = PHASE_BITS'(acc >> l_q);

   always_comb begin
      ramp_n = '0;
      case (state_n)
         ST_RAMP_UP:   ramp_n = 16'(pos);
         ST_HOLD:      ramp_n = RAMP_FULL;
         ST_RAMP_DOWN: ramp_n = RAMP_FULL - 16'(pos);
         default:      ramp_n = '0;
      endcase
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state        <= ST_IDLE;
         k            <= '0;
         l_q          <= '0;
         stop_pending <= 1'b0;
         ramp         <= '0;
         ramp_up_done <= 1'b0;
         done         <= 1'b0;
      end else begin
         state        <= state_n;
         k            <= k_n;
         l_q          <= l_n;
         stop_pending <= stop_pending_n;
         ramp         <= ramp_n;
         ramp_up_done <= (state_n == ST_HOLD) && (state != ST_HOLD);
         done         <= (state_n == ST_DONE) && (state != ST_DONE);
      end
   end

   assign state_o = state;
   assign busy    = (state == ST_ARMED) || (state == ST_RAMP_UP) ||
                    (state == ST_HOLD)  || (state == ST_RAMP_DOWN);

endmodule
